// File: rtl/sram_resp.sv
// Dual-port word SRAM that clears itself after reset, then serves an instruction port and a data port.
// Optional macro SRAM_RESP_BYPASS_EN forwards a same-cycle write on one port to a read of the same word on the other port.
module sram_resp #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        ready,
  output logic        err_oor
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic [31:0]     inst_rdata_q, inst_rdata_d;
  logic [31:0]     data_rdata_q, data_rdata_d;

  // NOTE: the storage array has no reset; the INIT sweep clears it instead.
  logic [31:0]     mem [DEPTH];

  logic [31:0]     inst_off, data_off;
  logic            inst_in, data_in;
  logic [AW-1:0]   inst_idx, data_idx;
  logic            run;
  logic            inst_wr, data_wr;
  logic [31:0]     inst_rd_val, data_rd_val;
  logic            unused_low_bits;

  // Wrap-around subtraction makes addresses below BASE land far out of range.
  always_comb begin
    inst_off = inst_sram_addr - BASE;
    data_off = data_sram_addr - BASE;
    inst_in  = (inst_off[31:AW+2] == '0);
    data_in  = (data_off[31:AW+2] == '0);
    inst_idx = inst_off[AW+1:2];
    data_idx = data_off[AW+1:2];
    run      = (state_q == S_RUN);
    inst_wr  = run & inst_sram_we & inst_in;
    data_wr  = run & data_sram_we & data_in;
  end

  assign unused_low_bits = ^{inst_off[1:0], data_off[1:0]};

  always_comb begin
    inst_rd_val = mem[inst_idx];
    data_rd_val = mem[data_idx];
`ifdef SRAM_RESP_BYPASS_EN
    if (data_wr && (data_idx == inst_idx)) inst_rd_val = data_sram_wdata;
    if (inst_wr && (inst_idx == data_idx)) data_rd_val = inst_sram_wdata;
`endif
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      S_INIT: begin
        cnt_d        = cnt_q + 1'b1;
        inst_rdata_d = '0;
        data_rdata_d = '0;
        if (cnt_q == AW'(DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (!inst_sram_we) inst_rdata_d = inst_in ? inst_rd_val : '0;
        if (!data_sram_we) data_rdata_d = data_in ? data_rd_val : '0;
        if (!inst_in || !data_in) err_d = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
    ready_d = (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Data-port write is issued last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state_q == S_INIT) begin
        mem[cnt_q] <= '0;
      end else begin
        if (inst_wr) mem[inst_idx] <= inst_sram_wdata;
        if (data_wr) mem[data_idx] <= data_sram_wdata;
      end
    end
  end

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;
  assign ready           = ready_q;
  assign err_oor         = err_q;

endmodule

// File: tb/tb_sram_resp.sv
// Scoreboard bench for sram_resp (DEPTH=16): expected rdata is queued when a request is driven and compared after the edge.
module tb_sram_resp;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_we, data_sram_we;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        ready, err_oor;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] inst_exp, data_exp;
  logic        err_exp;
  logic [31:0] inst_q [$];
  logic [31:0] data_q [$];

  sram_resp #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .ready           (ready),
    .err_oor         (err_oor)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    inst_sram_we    = 1'b0;
    inst_sram_addr  = BASE;
    inst_sram_wdata = '0;
    data_sram_we    = 1'b0;
    data_sram_addr  = BASE;
    data_sram_wdata = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    inst_exp = '0;
    data_exp = '0;
    err_exp  = 1'b0;
  endtask

  // One RUN-mode cycle on both ports, predicted by the bench model and checked after the edge.
  task automatic cyc(input logic iwe, input logic [31:0] ia, input logic [31:0] iwd,
                     input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    logic [31:0] ioff, doff, got_i, got_d;
    logic        iin, din;
    int          iidx, didx;
    inst_sram_we = iwe; inst_sram_addr = ia; inst_sram_wdata = iwd;
    data_sram_we = dwe; data_sram_addr = da; data_sram_wdata = dwd;
    ioff = ia - BASE;
    doff = da - BASE;
    iin  = (ioff < DEPTH * 4);
    din  = (doff < DEPTH * 4);
    iidx = int'(ioff[5:2]);
    didx = int'(doff[5:2]);
    if (!iwe) begin
      inst_exp = iin ? model_mem[iidx] : 32'h0;
`ifdef SRAM_RESP_BYPASS_EN
      if (iin && dwe && din && didx == iidx) inst_exp = dwd;
`endif
    end
    if (!dwe) begin
      data_exp = din ? model_mem[didx] : 32'h0;
`ifdef SRAM_RESP_BYPASS_EN
      if (din && iwe && iin && iidx == didx) data_exp = iwd;
`endif
    end
    inst_q.push_back(inst_exp);
    data_q.push_back(data_exp);
    if (!iin || !din) err_exp = 1'b1;
    if (iwe && iin) model_mem[iidx] = iwd;
    if (dwe && din) model_mem[didx] = dwd;
    @(posedge clk); #1;
    got_i = inst_q.pop_front();
    got_d = data_q.pop_front();
    n_checks++;
    if (inst_sram_rdata !== got_i) $display("FAIL inst_rdata addr=%h got=%h exp=%h", ia, inst_sram_rdata, got_i);
    else n_pass++;
    n_checks++;
    if (data_sram_rdata !== got_d) $display("FAIL data_rdata addr=%h got=%h exp=%h", da, data_sram_rdata, got_d);
    else n_pass++;
    n_checks++;
    if (err_oor !== err_exp) $display("FAIL err_oor got=%b exp=%b", err_oor, err_exp);
    else n_pass++;
  endtask

  // Counts edges after release until ready, while hammering the ports with requests INIT must ignore.
  task automatic wait_ready(input string tag, input int skip_edges);
    int n;
    bit bad;
    n = skip_edges;
    bad = 1'b0;
    inst_sram_we = 1'b1; inst_sram_addr = BASE; inst_sram_wdata = 32'hffffffff;
    data_sram_we = 1'b0; data_sram_addr = 32'h0; data_sram_wdata = '0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready === 1'b1) break;
      if (inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0 || err_oor !== 1'b0) bad = 1'b1;
    end
    drive_idle();
    n_checks++;
    if (n != DEPTH || ready !== 1'b1) $display("FAIL %s ready_latency got=%0d exp=%0d", tag, n, DEPTH);
    else n_pass++;
    n_checks++;
    if (bad) $display("FAIL %s init_outputs got=nonzero exp=zero", tag);
    else n_pass++;
    model_clear();
  endtask

  task automatic test_reset();
    drive_idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, err_oor, inst_sram_rdata, data_sram_rdata} !== 66'h0)
      $display("FAIL reset_state got=%b/%b/%h/%h exp=0/0/0/0", ready, err_oor, inst_sram_rdata, data_sram_rdata);
    else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_init();
    wait_ready("init", 0);
    cyc(1'b0, 32'h1c000020, '0, 1'b0, 32'h1c00003c, '0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, BASE + 32'(i * 4), '0, 1'b0, BASE + 32'(i * 4) + 32'd2, '0);
  endtask

  task automatic test_write_read();
    cyc(1'b0, BASE, '0, 1'b1, 32'h1c000008, 32'hdeadbeef);
    cyc(1'b0, 32'h1c00000b, '0, 1'b0, BASE, '0);
    cyc(1'b1, 32'h1c000010, 32'h0badf00d, 1'b0, 32'h1c000009, '0);
    cyc(1'b0, 32'h1c000010, '0, 1'b1, 32'h1c000014, 32'h01234567);
  endtask

  task automatic test_collision();
    cyc(1'b1, 32'h1c000004, 32'h11111111, 1'b1, 32'h1c000004, 32'h22222222);
    cyc(1'b0, 32'h1c000004, '0, 1'b0, 32'h1c000007, '0);
  endtask

  task automatic test_read_during_write();
    cyc(1'b0, 32'h1c000018, '0, 1'b1, BASE, 32'h12345678);
    cyc(1'b0, BASE, '0, 1'b1, BASE, 32'h55aa55aa);
    cyc(1'b1, 32'h1c00001c, 32'h77777777, 1'b0, 32'h1c00001c, '0);
    cyc(1'b0, BASE, '0, 1'b0, 32'h1c00001c, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 63)), $urandom,
          1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 63)), $urandom);
  endtask

  task automatic test_oor();
    cyc(1'b0, 32'h1bfffffc, '0, 1'b1, BASE + DEPTH * 4, 32'h00000bad);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, BASE + 32'(i * 4), '0, 1'b0, BASE + 32'(i * 4), '0);
    cyc(1'b1, 32'hffffffff, 32'h1, 1'b0, 32'h1c000008, '0);
  endtask

  task automatic test_reset_mid_init();
    cyc(1'b0, BASE, '0, 1'b1, 32'h1c00000c, 32'hcafef00d);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (err_oor !== 1'b0 || ready !== 1'b0) $display("FAIL midinit_reset got=%b/%b exp=0/0", err_oor, ready);
    else n_pass++;
    resetn = 1'b1;
    wait_ready("reinit", 0);
    cyc(1'b0, 32'h1c00000c, '0, 1'b0, 32'h1c00000c, '0);
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_collision();
    test_read_during_write();
    test_random();
    test_oor();
    test_reset_mid_init();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
